// File: rtl/collision_pkg.sv
// Shared constants and types for the sprite/background collision path.
// The border scanner walks a sprite outline and fetches the background under it.
package collision_pkg;

    localparam int SPRITE_SIZE = 16;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    localparam logic [1:0] EDGE_TOP    = 2'b00;
    localparam logic [1:0] EDGE_BOTTOM = 2'b01;
    localparam logic [1:0] EDGE_LEFT   = 2'b10;
    localparam logic [1:0] EDGE_RIGHT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_BOTTOM,
        S_LEFT,
        S_RIGHT,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/bg_border_scanner_addr_gen.sv
// Maps an 11-bit screen coordinate to a linear background word address.
// Addresses are only meaningful when on_screen is set.
module bg_addr_gen
    import collision_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic [18:0] mem_addr,
    output logic        on_screen
);

    logic [18:0] x_w;
    logic [18:0] y_w;

    // y*640 is formed as y*512 + y*128 to avoid a multiplier.
    always_comb begin
        x_w       = {8'd0, x};
        y_w       = {8'd0, y};
        on_screen = (x < 11'(SCREEN_W)) && (y < 11'(SCREEN_H));
        mem_addr  = (y_w << 9) + (y_w << 7) + x_w;
    end

endmodule

// File: rtl/bg_border_scanner.sv
// Walks the 16x16 outline of a sprite, reads the background pixel under each
// border position and streams it, tagged with coordinates and edge, to the checker.
module bg_border_scanner
    import collision_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  ancora_sp_X,
    input  logic [9:0]  ancora_sp_Y,
    output logic        mem_en,
    output logic [18:0] mem_addr,
    input  logic [23:0] mem_data,
    output logic [7:0]  R_bg,
    output logic [7:0]  G_bg,
    output logic [7:0]  B_bg,
    output logic [9:0]  ancora_bg_X,
    output logic [9:0]  ancora_bg_Y,
    output logic        pix_valid,
    output logic [1:0]  pix_edge,
    output logic        busy,
    output logic        done
);

    localparam logic [10:0] SPR_LAST = 11'(SPRITE_SIZE - 1);
    localparam logic [3:0]  IDX_LAST = 4'(SPRITE_SIZE - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  sx_q, sx_d;
    logic [9:0]  sy_q, sy_d;
    logic        pix_valid_q, pix_valid_d;
    logic        on_screen_q, on_screen_d;
    logic [9:0]  bg_x_q, bg_x_d;
    logic [9:0]  bg_y_q, bg_y_d;
    logic [1:0]  edge_q, edge_d;

    logic        issuing;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [1:0]  pix_edge_c;
    logic [18:0] addr_raw;
    logic        on_screen;

    always_comb begin
        issuing    = 1'b0;
        pix_x      = {1'b0, sx_q};
        pix_y      = {1'b0, sy_q};
        pix_edge_c = EDGE_TOP;
        case (state_q)
            S_TOP: begin
                issuing = 1'b1;
                pix_x   = {1'b0, sx_q} + {7'd0, idx_q};
            end
            S_BOTTOM: begin
                issuing    = 1'b1;
                pix_x      = {1'b0, sx_q} + {7'd0, idx_q};
                pix_y      = {1'b0, sy_q} + SPR_LAST;
                pix_edge_c = EDGE_BOTTOM;
            end
            S_LEFT: begin
                issuing    = 1'b1;
                pix_y      = {1'b0, sy_q} + {7'd0, idx_q};
                pix_edge_c = EDGE_LEFT;
            end
            S_RIGHT: begin
                issuing    = 1'b1;
                pix_x      = {1'b0, sx_q} + SPR_LAST;
                pix_y      = {1'b0, sy_q} + {7'd0, idx_q};
                pix_edge_c = EDGE_RIGHT;
            end
            default: ;
        endcase
    end

    bg_addr_gen u_addr_gen (
        .x         (pix_x),
        .y         (pix_y),
        .mem_addr  (addr_raw),
        .on_screen (on_screen)
    );

    // Each edge takes SPRITE_SIZE cycles; idx wraps naturally at the handoff.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TOP;
                    idx_d   = 4'd0;
                    sx_d    = ancora_sp_X;
                    sy_d    = ancora_sp_Y;
                end
            end
            S_TOP: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == IDX_LAST) state_d = S_BOTTOM;
            end
            S_BOTTOM: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == IDX_LAST) state_d = S_LEFT;
            end
            S_LEFT: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == IDX_LAST) state_d = S_RIGHT;
            end
            S_RIGHT: begin
                idx_d = idx_q + 4'd1;
                if (idx_q == IDX_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel tag follows its memory read by one cycle so it meets mem_data.
    always_comb begin
        pix_valid_d = issuing;
        on_screen_d = issuing && on_screen;
        bg_x_d      = issuing ? pix_x[9:0] : 10'd0;
        bg_y_d      = issuing ? pix_y[9:0] : 10'd0;
        edge_d      = issuing ? pix_edge_c : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            sx_q        <= 10'd0;
            sy_q        <= 10'd0;
            pix_valid_q <= 1'b0;
            on_screen_q <= 1'b0;
            bg_x_q      <= 10'd0;
            bg_y_q      <= 10'd0;
            edge_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            pix_valid_q <= pix_valid_d;
            on_screen_q <= on_screen_d;
            bg_x_q      <= bg_x_d;
            bg_y_q      <= bg_y_d;
            edge_q      <= edge_d;
        end
    end

    // Off-screen pixels never read memory and report black.
    always_comb begin
        mem_en      = issuing && on_screen;
        mem_addr    = mem_en ? addr_raw : 19'd0;
        {R_bg, G_bg, B_bg} = on_screen_q ? mem_data : 24'd0;
        ancora_bg_X = bg_x_q;
        ancora_bg_Y = bg_y_q;
        pix_valid   = pix_valid_q;
        pix_edge    = edge_q;
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
    end

endmodule
